mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage of the RV32I core, the consumer of the execute stage's result/address/store-data outputs. Passes ALU results straight to writeback, and turns load/store opcodes into one data-memory transaction each over a req/gnt/rvalid bus. Generates byte enables and store lane replication, and aligns and extends load data. Stalls the execute stage through a ready signal while a memory transaction is outstanding.

## Interface
Parameters:
- OPW, 11, opcode width; encoding shared with execute: LH=0, LB=1, LW=2, LBU=3, LHU=4, SW=5, SH=6, SB=7, any other value = non-memory op

Ports:
- clk  in  1  clock, single domain
- rstl  in  1  reset, synchronous, active-low
- valid_exe_2_mem_i  in  1  execute presents an instruction
- ready_mem_2_exe_o  out  1  stage accepts; transfer when valid & ready
- opcode_exe_2_mem_i  in  OPW  operation type
- rd_exe_2_mem_i  in  5  destination register
- rd_data_exe_2_mem_i  in  32  ALU result (non-memory ops)
- mem_address_i  in  32  byte address for load/store
- mem_data_i  in  32  store data, low bits significant
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word address, {addr[31:2],2'b00}
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read word
- wb_valid_o  out  1  one-cycle writeback pulse
- wb_we_o  out  1  register write enable (0 for stores and rd=0)
- wb_rd_o  out  5  writeback register
- wb_data_o  out  32  writeback data
- misaligned_o  out  1  one-cycle misaligned-access pulse
- misaligned_addr_o  out  32  offending address, held until next pulse

## Operation
- FSM states: IDLE, REQ, WAIT_R. ready_mem_2_exe_o = (state==IDLE) & rstl.
- IDLE, accept of non-memory op: next cycle wb_valid_o=1, wb_data_o=rd_data_exe_2_mem_i, wb_rd_o=rd, wb_we_o=(rd!=0); stay IDLE (back-to-back accepts allowed).
- IDLE, accept of memory op: alignment check — LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops are always aligned.
  - Misaligned: next cycle misaligned_o=1, misaligned_addr_o=addr; no dmem request, no wb pulse; stay IDLE.
  - Aligned: latch op/rd/addr/data and go to REQ.
- REQ: dmem_req_o=1 with addr/we/be/wdata stable until dmem_gnt_i.
  - Store + gnt: go to IDLE; next cycle wb_valid_o=1, wb_we_o=0.
  - Load + gnt: go to WAIT_R.
- WAIT_R: dmem_req_o=0; wait any number of cycles for dmem_rvalid_i. On rvalid, select and extend:
  - LB/LBU: byte at addr[1:0], sign/zero extended.
  - LH/LHU: half at addr[1], sign/zero extended.
  - LW: full word.
  - Next cycle wb_valid_o=1, wb_we_o=(rd!=0); go to IDLE.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{d[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata={2{d[15:0]}}.
  - SW: be=1111, wdata=d.
  - Loads: be=1111, we=0, wdata=0.
- dmem_rvalid_i outside WAIT_R and dmem_gnt_i outside REQ are ignored.
- wb_data_o/wb_rd_o hold their last value when wb_valid_o=0.

## Timing
- Reset (rstl low at a clk edge): state=IDLE; all outputs 0, including ready_mem_2_exe_o while rstl is low. Any in-flight transaction is abandoned; a late rvalid after reset is ignored.
- Accept at cycle N:
  - Non-memory: wb at N+1.
  - Misaligned: misaligned_o at N+1.
  - Memory: dmem_req_o at N+1.
- Grant at cycle G:
  - Store: wb pulse at G+1; ready high at G+1.
  - Load: rvalid is sampled from G+1 onward; rvalid at R gives wb at R+1 and ready high at R+1.
- Minimum latencies: store 2 cycles (gnt in first REQ cycle); load 3 cycles.
- All outputs except ready_mem_2_exe_o are registered.

## Test plan
- ADD result 0x12345678, rd=5, then accept next cycle, rd=0 value 0xFFFFFFFF -> wb pulses on consecutive cycles: (5, 0x12345678, we=1), then (0, we=0).
- SB addr 0x1003, data 0x000000A5, gnt delayed 3 cycles -> req held 4 cycles with addr 0x1000, be=1000, wdata 0xA5A5A5A5; wb_we=0 pulse the cycle after gnt; ready low throughout.
- LB addr 0x2002, rdata 0x80FF7F01 -> wb_data 0xFFFFFFFF; LBU same -> 0x000000FF; LH addr 0x2002 -> 0xFFFF80FF; LHU -> 0x000080FF.
- LW addr 0x3002 -> misaligned_o pulse, misaligned_addr_o=0x3002, no dmem_req, no wb; SH addr 0x3001 gives the same behaviour.
- LW accepted, gnt, then rstl low for 1 cycle before rvalid -> all outputs 0, rvalid arriving after reset produces no wb, next ADD completes normally.
- LW with gnt and rvalid delayed 5 cycles, valid held by execute -> no second accept until wb; wb_data equals rdata.

Source files
------------

// File: rtl/mem_stage_if.sv
// mem_stage data-memory bus.
// req/gnt request phase, rvalid response phase.
interface mem_stage_if;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    modport master (
        output dmem_req_o,
        output dmem_we_o,
        output dmem_addr_o,
        output dmem_be_o,
        output dmem_wdata_o,
        input  dmem_gnt_i,
        input  dmem_rvalid_i,
        input  dmem_rdata_i
    );

    modport slave (
        input  dmem_req_o,
        input  dmem_we_o,
        input  dmem_addr_o,
        input  dmem_be_o,
        input  dmem_wdata_o,
        output dmem_gnt_i,
        output dmem_rvalid_i,
        output dmem_rdata_i
    );
endinterface

// File: rtl/mem_stage.sv
// RV32I memory-access stage.
// ALU results pass through; loads/stores run one dmem transaction.
module mem_stage #(
    parameter int OPW = 11
) (
    input  logic            clk,
    input  logic            rstl,
    input  logic            valid_exe_2_mem_i,
    output logic            ready_mem_2_exe_o,
    input  logic [OPW-1:0]  opcode_exe_2_mem_i,
    input  logic [4:0]      rd_exe_2_mem_i,
    input  logic [31:0]     rd_data_exe_2_mem_i,
    input  logic [31:0]     mem_address_i,
    input  logic [31:0]     mem_data_i,
    mem_stage_if.master     dmem,
    output logic            wb_valid_o,
    output logic            wb_we_o,
    output logic [4:0]      wb_rd_o,
    output logic [31:0]     wb_data_o,
    output logic            misaligned_o,
    output logic [31:0]     misaligned_addr_o
);

    localparam logic [OPW-1:0] OP_LH  = OPW'(0);
    localparam logic [OPW-1:0] OP_LB  = OPW'(1);
    localparam logic [OPW-1:0] OP_LW  = OPW'(2);
    localparam logic [OPW-1:0] OP_LBU = OPW'(3);
    localparam logic [OPW-1:0] OP_LHU = OPW'(4);
    localparam logic [OPW-1:0] OP_SW  = OPW'(5);
    localparam logic [OPW-1:0] OP_SH  = OPW'(6);
    localparam logic [OPW-1:0] OP_SB  = OPW'(7);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic           accept;
    logic           is_mem;
    logic           is_store;
    logic           misal;
    logic [3:0]     be_in;
    logic [31:0]    wdata_in;

    logic [OPW-1:0] op_q;
    logic [4:0]     rd_q;
    logic [31:0]    addr_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;
    logic           we_q;

    logic [7:0]     ld_byte;
    logic [15:0]    ld_half;
    logic [31:0]    ld_data;

    assign accept   = valid_exe_2_mem_i & ready_mem_2_exe_o;
    assign is_mem   = opcode_exe_2_mem_i <= OP_SB;
    assign is_store = (opcode_exe_2_mem_i == OP_SW) |
                      (opcode_exe_2_mem_i == OP_SH) |
                      (opcode_exe_2_mem_i == OP_SB);

    // Alignment rule and store lane placement for the incoming op.
    always_comb begin
        misal    = 1'b0;
        be_in    = 4'b1111;
        wdata_in = 32'h0;
        unique case (1'b1)
            (opcode_exe_2_mem_i == OP_LH),
            (opcode_exe_2_mem_i == OP_LHU): begin
                misal = mem_address_i[0];
            end
            (opcode_exe_2_mem_i == OP_LW): begin
                misal = |mem_address_i[1:0];
            end
            (opcode_exe_2_mem_i == OP_SW): begin
                misal    = |mem_address_i[1:0];
                wdata_in = mem_data_i;
            end
            (opcode_exe_2_mem_i == OP_SH): begin
                misal    = mem_address_i[0];
                be_in    = mem_address_i[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{mem_data_i[15:0]}};
            end
            (opcode_exe_2_mem_i == OP_SB): begin
                be_in    = 4'b0001 << mem_address_i[1:0];
                wdata_in = {4{mem_data_i[7:0]}};
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstl) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept && is_mem && !misal) state_nxt = REQ;
            end
            REQ: begin
                if (dmem.dmem_gnt_i) state_nxt = we_q ? IDLE : WAIT_R;
            end
            WAIT_R: begin
                if (dmem.dmem_rvalid_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ready_mem_2_exe_o = (state == IDLE) & rstl;
        dmem.dmem_req_o   = (state == REQ);
    end

    assign dmem.dmem_we_o    = we_q;
    assign dmem.dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem.dmem_be_o    = be_q;
    assign dmem.dmem_wdata_o = wdata_q;

    // Capture the accepted memory op for the whole transaction.
    always_ff @(posedge clk) begin
        if (!rstl) begin
            op_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else if (accept && is_mem && !misal) begin
            op_q    <= opcode_exe_2_mem_i;
            rd_q    <= rd_exe_2_mem_i;
            addr_q  <= mem_address_i;
            be_q    <= be_in;
            wdata_q <= wdata_in;
            we_q    <= is_store;
        end
    end

    // Select and extend the returned load data.
    always_comb begin
        ld_byte = 8'h0;
        unique case (addr_q[1:0])
            2'd0: ld_byte = dmem.dmem_rdata_i[7:0];
            2'd1: ld_byte = dmem.dmem_rdata_i[15:8];
            2'd2: ld_byte = dmem.dmem_rdata_i[23:16];
            2'd3: ld_byte = dmem.dmem_rdata_i[31:24];
            default: ;
        endcase
        ld_half = addr_q[1] ? dmem.dmem_rdata_i[31:16]
                            : dmem.dmem_rdata_i[15:0];
        ld_data = dmem.dmem_rdata_i;
        unique case (1'b1)
            (op_q == OP_LB):  ld_data = {{24{ld_byte[7]}}, ld_byte};
            (op_q == OP_LBU): ld_data = {24'h0, ld_byte};
            (op_q == OP_LH):  ld_data = {{16{ld_half[15]}}, ld_half};
            (op_q == OP_LHU): ld_data = {16'h0, ld_half};
            default: ;
        endcase
    end

    // Writeback and misalignment pulses.
    always_ff @(posedge clk) begin
        if (!rstl) begin
            wb_valid_o        <= 1'b0;
            wb_we_o           <= 1'b0;
            wb_rd_o           <= '0;
            wb_data_o         <= '0;
            misaligned_o      <= 1'b0;
            misaligned_addr_o <= '0;
        end else begin
            wb_valid_o   <= 1'b0;
            misaligned_o <= 1'b0;
            if (accept && !is_mem) begin
                wb_valid_o <= 1'b1;
                wb_we_o    <= rd_exe_2_mem_i != 5'd0;
                wb_rd_o    <= rd_exe_2_mem_i;
                wb_data_o  <= rd_data_exe_2_mem_i;
            end else if (accept && misal) begin
                misaligned_o      <= 1'b1;
                misaligned_addr_o <= mem_address_i;
            end else if (state == REQ && dmem.dmem_gnt_i && we_q) begin
                wb_valid_o <= 1'b1;
                wb_we_o    <= 1'b0;
                wb_rd_o    <= rd_q;
            end else if (state == WAIT_R && dmem.dmem_rvalid_i) begin
                wb_valid_o <= 1'b1;
                wb_we_o    <= rd_q != 5'd0;
                wb_rd_o    <= rd_q;
                wb_data_o  <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage.
// Bus responses are driven cycle by cycle from the stimulus.
module tb_mem_stage;

    localparam int OPW = 11;
    localparam logic [OPW-1:0] LH  = 11'd0;
    localparam logic [OPW-1:0] LB  = 11'd1;
    localparam logic [OPW-1:0] LW  = 11'd2;
    localparam logic [OPW-1:0] LBU = 11'd3;
    localparam logic [OPW-1:0] LHU = 11'd4;
    localparam logic [OPW-1:0] SW  = 11'd5;
    localparam logic [OPW-1:0] SH  = 11'd6;
    localparam logic [OPW-1:0] SB  = 11'd7;
    localparam logic [OPW-1:0] ADD = 11'd20;

    logic           clk = 1'b0;
    logic           rstl;
    logic           valid;
    logic           ready;
    logic [OPW-1:0] opcode;
    logic [4:0]     rd;
    logic [31:0]    rd_data;
    logic [31:0]    addr;
    logic [31:0]    mdata;
    logic           wb_valid;
    logic           wb_we;
    logic [4:0]     wb_rd;
    logic [31:0]    wb_data;
    logic           misaligned;
    logic [31:0]    misaligned_addr;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_if dmem ();

    mem_stage #(.OPW(OPW)) dut (
        .clk                 (clk),
        .rstl                (rstl),
        .valid_exe_2_mem_i   (valid),
        .ready_mem_2_exe_o   (ready),
        .opcode_exe_2_mem_i  (opcode),
        .rd_exe_2_mem_i      (rd),
        .rd_data_exe_2_mem_i (rd_data),
        .mem_address_i       (addr),
        .mem_data_i          (mdata),
        .dmem                (dmem.master),
        .wb_valid_o          (wb_valid),
        .wb_we_o             (wb_we),
        .wb_rd_o             (wb_rd),
        .wb_data_o           (wb_data),
        .misaligned_o        (misaligned),
        .misaligned_addr_o   (misaligned_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_store(input logic [OPW-1:0] op,
                            input logic [31:0] a,
                            input logic [31:0] d,
                            input int gd,
                            input logic [31:0] exp_addr,
                            input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        valid = 1'b1; opcode = op; rd = 5'd9; addr = a; mdata = d;
        tick();
        valid = 1'b0;
        for (int i = 0; i <= gd; i++) begin
            check("st_req", 32'(dmem.dmem_req_o), 32'd1);
            check("st_we", 32'(dmem.dmem_we_o), 32'd1);
            check("st_addr", dmem.dmem_addr_o, exp_addr);
            check("st_be", 32'(dmem.dmem_be_o), 32'(exp_be));
            check("st_wdata", dmem.dmem_wdata_o, exp_wd);
            check("st_ready", 32'(ready), 32'd0);
            check("st_nowb", 32'(wb_valid), 32'd0);
            dmem.dmem_gnt_i = (i == gd);
            tick();
        end
        dmem.dmem_gnt_i = 1'b0;
        check("st_wb", 32'(wb_valid), 32'd1);
        check("st_wbwe", 32'(wb_we), 32'd0);
        check("st_req_off", 32'(dmem.dmem_req_o), 32'd0);
        check("st_ready_up", 32'(ready), 32'd1);
    endtask

    task automatic do_load(input logic [OPW-1:0] op,
                           input logic [31:0] a,
                           input logic [31:0] rdata,
                           input int gd,
                           input int rvd,
                           input logic hold,
                           input logic [31:0] exp);
        valid = 1'b1; opcode = op; rd = 5'd7; addr = a;
        tick();
        valid = hold;
        for (int i = 0; i <= gd; i++) begin
            check("ld_req", 32'(dmem.dmem_req_o), 32'd1);
            check("ld_we", 32'(dmem.dmem_we_o), 32'd0);
            check("ld_be", 32'(dmem.dmem_be_o), 32'hF);
            check("ld_ready", 32'(ready), 32'd0);
            dmem.dmem_gnt_i = (i == gd);
            tick();
        end
        dmem.dmem_gnt_i = 1'b0;
        for (int i = 0; i <= rvd; i++) begin
            check("ld_wait_req", 32'(dmem.dmem_req_o), 32'd0);
            check("ld_wait_ready", 32'(ready), 32'd0);
            check("ld_wait_nowb", 32'(wb_valid), 32'd0);
            dmem.dmem_rvalid_i = (i == rvd);
            dmem.dmem_rdata_i  = rdata;
            tick();
        end
        dmem.dmem_rvalid_i = 1'b0;
        valid = 1'b0;
        check("ld_wb", 32'(wb_valid), 32'd1);
        check("ld_wbwe", 32'(wb_we), 32'd1);
        check("ld_rd", 32'(wb_rd), 32'd7);
        check("ld_data", wb_data, exp);
        check("ld_ready_up", 32'(ready), 32'd1);
    endtask

    task automatic do_misal(input logic [OPW-1:0] op,
                            input logic [31:0] a);
        valid = 1'b1; opcode = op; rd = 5'd4; addr = a;
        tick();
        valid = 1'b0;
        check("mis_pulse", 32'(misaligned), 32'd1);
        check("mis_addr", misaligned_addr, a);
        check("mis_noreq", 32'(dmem.dmem_req_o), 32'd0);
        check("mis_nowb", 32'(wb_valid), 32'd0);
        check("mis_ready", 32'(ready), 32'd1);
        tick();
        check("mis_drop", 32'(misaligned), 32'd0);
        check("mis_hold", misaligned_addr, a);
        check("mis_noreq2", 32'(dmem.dmem_req_o), 32'd0);
    endtask

    initial begin
        rstl = 1'b0; valid = 1'b0; opcode = ADD; rd = 5'd0;
        rd_data = 32'h0; addr = 32'h0; mdata = 32'h0;
        dmem.dmem_gnt_i = 1'b0;
        dmem.dmem_rvalid_i = 1'b0;
        dmem.dmem_rdata_i = 32'h0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_req", 32'(dmem.dmem_req_o), 32'd0);
        check("rst_wb", 32'(wb_valid), 32'd0);
        check("rst_wbdata", wb_data, 32'h0);
        check("rst_mis", 32'(misaligned), 32'd0);
        rstl = 1'b1;
        #1;
        check("rst_ready_up", 32'(ready), 32'd1);

        valid = 1'b1; opcode = ADD; rd = 5'd5; rd_data = 32'h12345678;
        tick();
        rd = 5'd0; rd_data = 32'hFFFFFFFF;
        check("alu0_wb", 32'(wb_valid), 32'd1);
        check("alu0_rd", 32'(wb_rd), 32'd5);
        check("alu0_data", wb_data, 32'h12345678);
        check("alu0_we", 32'(wb_we), 32'd1);
        check("alu0_ready", 32'(ready), 32'd1);
        tick();
        valid = 1'b0;
        check("alu1_wb", 32'(wb_valid), 32'd1);
        check("alu1_rd", 32'(wb_rd), 32'd0);
        check("alu1_data", wb_data, 32'hFFFFFFFF);
        check("alu1_we", 32'(wb_we), 32'd0);
        tick();
        check("alu_idle", 32'(wb_valid), 32'd0);
        check("alu_hold", wb_data, 32'hFFFFFFFF);

        do_store(SB, 32'h00001003, 32'h000000A5, 3,
                 32'h00001000, 4'b1000, 32'hA5A5A5A5);
        do_store(SH, 32'h00001002, 32'h1234BEEF, 0,
                 32'h00001000, 4'b1100, 32'hBEEFBEEF);
        do_store(SB, 32'h00001001, 32'h00000037, 1,
                 32'h00001000, 4'b0010, 32'h37373737);
        do_store(SW, 32'h00001004, 32'hDEADBEEF, 0,
                 32'h00001004, 4'b1111, 32'hDEADBEEF);

        do_load(LB,  32'h00002002, 32'h80FF7F01, 0, 0, 1'b0, 32'hFFFFFFFF);
        do_load(LBU, 32'h00002002, 32'h80FF7F01, 0, 0, 1'b0, 32'h000000FF);
        do_load(LH,  32'h00002002, 32'h80FF7F01, 1, 2, 1'b0, 32'hFFFF80FF);
        do_load(LHU, 32'h00002002, 32'h80FF7F01, 0, 1, 1'b0, 32'h000080FF);
        do_load(LB,  32'h00002000, 32'h80FF7F01, 0, 0, 1'b0, 32'h00000001);
        do_load(LH,  32'h00002000, 32'h80FF7F01, 0, 0, 1'b0, 32'h00007F01);

        do_misal(LW, 32'h00003002);
        do_misal(SH, 32'h00003001);

        valid = 1'b1; opcode = LW; rd = 5'd7; addr = 32'h00004000;
        tick();
        valid = 1'b0;
        dmem.dmem_gnt_i = 1'b1;
        tick();
        dmem.dmem_gnt_i = 1'b0;
        rstl = 1'b0;
        tick();
        check("mrst_ready", 32'(ready), 32'd0);
        check("mrst_req", 32'(dmem.dmem_req_o), 32'd0);
        check("mrst_wb", 32'(wb_valid), 32'd0);
        check("mrst_wbdata", wb_data, 32'h0);
        check("mrst_wbrd", 32'(wb_rd), 32'd0);
        check("mrst_misaddr", misaligned_addr, 32'h0);
        check("mrst_addr", dmem.dmem_addr_o, 32'h0);
        rstl = 1'b1;
        dmem.dmem_rvalid_i = 1'b1;
        dmem.dmem_rdata_i = 32'h55555555;
        tick();
        dmem.dmem_rvalid_i = 1'b0;
        check("late_rv_nowb", 32'(wb_valid), 32'd0);
        check("late_rv_ready", 32'(ready), 32'd1);
        valid = 1'b1; opcode = ADD; rd = 5'd3; rd_data = 32'hCAFEF00D;
        tick();
        valid = 1'b0;
        check("post_wb", 32'(wb_valid), 32'd1);
        check("post_rd", 32'(wb_rd), 32'd3);
        check("post_data", wb_data, 32'hCAFEF00D);

        do_load(LW, 32'h00005008, 32'h89ABCDEF, 0, 5, 1'b1, 32'h89ABCDEF);
        tick();
        check("hold_idle_wb", 32'(wb_valid), 32'd0);
        check("hold_idle_req", 32'(dmem.dmem_req_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
